// File: rtl/icw_ocw_control_8259.sv
// 8259A command-word register stage: ICW1..ICW4 sequencing, OCW1..OCW3
// storage and one-cycle OCW2/OCW3 command pulses.
module icw_ocw_control_8259 #(
    parameter logic [7:0] MASK_RESET_VALUE = 8'h00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] internal_data_bus,
    input  logic       write_initial_command_word_1,
    input  logic       write_initial_command_word_2_4,
    input  logic       write_operation_control_word_1,
    input  logic       write_operation_control_word_2,
    input  logic       write_operation_control_word_3,
    output logic       ready,
    output logic       level_triggered,
    output logic       call_interval4,
    output logic       single_mode,
    output logic       icw4_needed,
    output logic [7:0] icw2_vector,
    output logic [7:0] cascade_config,
    output logic       upm_8086,
    output logic       auto_eoi,
    output logic       buffered_master,
    output logic       buffered_mode,
    output logic       special_fully_nested,
    output logic [7:0] interrupt_mask,
    output logic [2:0] ocw2_level,
    output logic       eoi_pulse,
    output logic       specific_eoi_pulse,
    output logic       rotate_eoi_pulse,
    output logic       specific_rotate_pulse,
    output logic       set_priority_pulse,
    output logic       auto_rotate_mode,
    output logic       special_mask_mode,
    output logic       read_isr_select,
    output logic       poll_pulse
);

    typedef enum logic [2:0] {
        WAIT_ICW1 = 3'd0,
        ICW2      = 3'd1,
        ICW3      = 3'd2,
        ICW4      = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic icw1_q;
    logic a0_q;
    logic ocw2_q;
    logic ocw3_q;

    logic a0_strobe;
    logic icw1_ev;
    logic a0_ev;
    logic ocw2_ev;
    logic ocw3_ev;

    // Both A0=1 strobes describe the same bus write, so merge them first.
    assign a0_strobe = write_initial_command_word_2_4 | write_operation_control_word_1;

    assign icw1_ev = write_initial_command_word_1   & ~icw1_q;
    assign a0_ev   = a0_strobe                      & ~a0_q;
    assign ocw2_ev = write_operation_control_word_2 & ~ocw2_q;
    assign ocw3_ev = write_operation_control_word_3 & ~ocw3_q;

    // Strobe history for rising-edge event detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            icw1_q <= 1'b0;
            a0_q   <= 1'b0;
            ocw2_q <= 1'b0;
            ocw3_q <= 1'b0;
        end else begin
            icw1_q <= write_initial_command_word_1;
            a0_q   <= a0_strobe;
            ocw2_q <= write_operation_control_word_2;
            ocw3_q <= write_operation_control_word_3;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_ICW1;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next state; ICW1 restarts the sequence from anywhere.
    always_comb begin
        state_next = state;
        if (icw1_ev) begin
            state_next = ICW2;
        end else if (a0_ev) begin
            case (state)
                ICW2: begin
                    if (!single_mode)     state_next = ICW3;
                    else if (icw4_needed) state_next = ICW4;
                    else                  state_next = READY;
                end
                ICW3:    state_next = icw4_needed ? ICW4 : READY;
                ICW4:    state_next = READY;
                default: state_next = state;
            endcase
        end
    end

    // Configuration registers and command pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready                 <= 1'b0;
            level_triggered       <= 1'b0;
            call_interval4        <= 1'b0;
            single_mode           <= 1'b0;
            icw4_needed           <= 1'b0;
            icw2_vector           <= 8'h00;
            cascade_config        <= 8'h00;
            upm_8086              <= 1'b0;
            auto_eoi              <= 1'b0;
            buffered_master       <= 1'b0;
            buffered_mode         <= 1'b0;
            special_fully_nested  <= 1'b0;
            interrupt_mask        <= MASK_RESET_VALUE;
            ocw2_level            <= 3'd0;
            eoi_pulse             <= 1'b0;
            specific_eoi_pulse    <= 1'b0;
            rotate_eoi_pulse      <= 1'b0;
            specific_rotate_pulse <= 1'b0;
            set_priority_pulse    <= 1'b0;
            auto_rotate_mode      <= 1'b0;
            special_mask_mode     <= 1'b0;
            read_isr_select       <= 1'b0;
            poll_pulse            <= 1'b0;
        end else begin
            eoi_pulse             <= 1'b0;
            specific_eoi_pulse    <= 1'b0;
            rotate_eoi_pulse      <= 1'b0;
            specific_rotate_pulse <= 1'b0;
            set_priority_pulse    <= 1'b0;
            poll_pulse            <= 1'b0;
            ready                 <= (state_next == READY);

            if (icw1_ev) begin
                level_triggered      <= internal_data_bus[3];
                call_interval4       <= internal_data_bus[2];
                single_mode          <= internal_data_bus[1];
                icw4_needed          <= internal_data_bus[0];
                interrupt_mask       <= MASK_RESET_VALUE;
                upm_8086             <= 1'b0;
                auto_eoi             <= 1'b0;
                buffered_master      <= 1'b0;
                buffered_mode        <= 1'b0;
                special_fully_nested <= 1'b0;
                special_mask_mode    <= 1'b0;
                read_isr_select      <= 1'b0;
                auto_rotate_mode     <= 1'b0;
            end else begin
                if (a0_ev) begin
                    case (state)
                        ICW2:  icw2_vector    <= internal_data_bus;
                        ICW3:  cascade_config <= internal_data_bus;
                        ICW4: begin
                            upm_8086             <= internal_data_bus[0];
                            auto_eoi             <= internal_data_bus[1];
                            buffered_master      <= internal_data_bus[2];
                            buffered_mode        <= internal_data_bus[3];
                            special_fully_nested <= internal_data_bus[4];
                        end
                        READY: interrupt_mask <= internal_data_bus;
                        default: ;
                    endcase
                end

                if (ocw2_ev && (state == READY)) begin
                    ocw2_level <= internal_data_bus[2:0];
                    case (internal_data_bus[7:5])
                        3'b001:  eoi_pulse             <= 1'b1;
                        3'b011:  specific_eoi_pulse    <= 1'b1;
                        3'b101:  rotate_eoi_pulse      <= 1'b1;
                        3'b111:  specific_rotate_pulse <= 1'b1;
                        3'b110:  set_priority_pulse    <= 1'b1;
                        3'b100:  auto_rotate_mode      <= 1'b1;
                        3'b000:  auto_rotate_mode      <= 1'b0;
                        default: ;
                    endcase
                end

                if (ocw3_ev && (state == READY)) begin
                    if (internal_data_bus[6]) special_mask_mode <= internal_data_bus[5];
                    if (internal_data_bus[2]) poll_pulse        <= 1'b1;
                    if (internal_data_bus[1]) read_isr_select   <= internal_data_bus[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_icw_ocw_control_8259.sv
// Directed vector bench for the 8259 ICW/OCW command-register stage.
module tb_icw_ocw_control_8259;

    localparam int OP_NONE = 0;
    localparam int OP_ICW1 = 1;
    localparam int OP_A0   = 2;
    localparam int OP_OCW2 = 3;
    localparam int OP_OCW3 = 4;
    localparam int OP_BOTH = 5;
    localparam int NVEC    = 33;
    localparam int NPRE    = 29;

    typedef struct packed {
        logic       rdy;
        logic [3:0] icw1;
        logic [7:0] vec;
        logic [7:0] cas;
        logic [4:0] icw4;
        logic [7:0] mask;
        logic [2:0] lvl;
        logic       arm;
        logic       smm;
        logic       ris;
        logic [5:0] pulses;
    } obs_t;

    typedef struct {
        int         op;
        logic [7:0] data;
        int         hold;
        obs_t       exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] internal_data_bus = 8'h00;
    logic       w_icw1 = 1'b0;
    logic       w_icw24 = 1'b0;
    logic       w_ocw1 = 1'b0;
    logic       w_ocw2 = 1'b0;
    logic       w_ocw3 = 1'b0;

    logic       ready, level_triggered, call_interval4, single_mode, icw4_needed;
    logic [7:0] icw2_vector, cascade_config, interrupt_mask;
    logic       upm_8086, auto_eoi, buffered_master, buffered_mode, special_fully_nested;
    logic [2:0] ocw2_level;
    logic       eoi_pulse, specific_eoi_pulse, rotate_eoi_pulse, specific_rotate_pulse;
    logic       set_priority_pulse, auto_rotate_mode, special_mask_mode, read_isr_select, poll_pulse;

    int applied = 0;
    int miscompares = 0;
    vec_t vt[NVEC];
    obs_t obs;

    icw_ocw_control_8259 #(.MASK_RESET_VALUE(8'h00)) dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (w_icw1),
        .write_initial_command_word_2_4 (w_icw24),
        .write_operation_control_word_1 (w_ocw1),
        .write_operation_control_word_2 (w_ocw2),
        .write_operation_control_word_3 (w_ocw3),
        .ready                          (ready),
        .level_triggered                (level_triggered),
        .call_interval4                 (call_interval4),
        .single_mode                    (single_mode),
        .icw4_needed                    (icw4_needed),
        .icw2_vector                    (icw2_vector),
        .cascade_config                 (cascade_config),
        .upm_8086                       (upm_8086),
        .auto_eoi                       (auto_eoi),
        .buffered_master                (buffered_master),
        .buffered_mode                  (buffered_mode),
        .special_fully_nested           (special_fully_nested),
        .interrupt_mask                 (interrupt_mask),
        .ocw2_level                     (ocw2_level),
        .eoi_pulse                      (eoi_pulse),
        .specific_eoi_pulse             (specific_eoi_pulse),
        .rotate_eoi_pulse               (rotate_eoi_pulse),
        .specific_rotate_pulse          (specific_rotate_pulse),
        .set_priority_pulse             (set_priority_pulse),
        .auto_rotate_mode               (auto_rotate_mode),
        .special_mask_mode              (special_mask_mode),
        .read_isr_select                (read_isr_select),
        .poll_pulse                     (poll_pulse)
    );

    always #5 clock = ~clock;

    assign obs = {ready,
                  {level_triggered, call_interval4, single_mode, icw4_needed},
                  icw2_vector, cascade_config,
                  {special_fully_nested, buffered_mode, buffered_master, auto_eoi, upm_8086},
                  interrupt_mask, ocw2_level,
                  auto_rotate_mode, special_mask_mode, read_isr_select,
                  {eoi_pulse, specific_eoi_pulse, rotate_eoi_pulse,
                   specific_rotate_pulse, set_priority_pulse, poll_pulse}};

    function automatic obs_t e(input logic r, input logic [3:0] i1, input logic [7:0] v,
                               input logic [7:0] c, input logic [4:0] i4, input logic [7:0] m,
                               input logic [2:0] l, input logic a, input logic s,
                               input logic ri, input logic [5:0] p);
        return {r, i1, v, c, i4, m, l, a, s, ri, p};
    endfunction

    task automatic check(input string nm, input obs_t exp);
        applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic drive(input int op, input logic v);
        case (op)
            OP_ICW1: w_icw1 = v;
            OP_A0:   begin w_icw24 = v; w_ocw1 = v; end
            OP_OCW2: w_ocw2 = v;
            OP_OCW3: w_ocw3 = v;
            OP_BOTH: begin w_icw1 = v; w_icw24 = v; w_ocw1 = v; end
            default: ;
        endcase
    endtask

    // One write: strobe held 'hold' cycles, checked at the event edge and after.
    task automatic apply(input int idx);
        obs_t held;
        @(negedge clock);
        internal_data_bus = vt[idx].data;
        drive(vt[idx].op, 1'b1);
        @(posedge clock);
        #1;
        check($sformatf("vec%0d", idx), vt[idx].exp);
        held = vt[idx].exp;
        held.pulses = 6'b0;
        for (int i = 1; i < vt[idx].hold; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_hold%0d", idx, i), held);
        end
        @(negedge clock);
        drive(vt[idx].op, 1'b0);
    endtask

    initial begin
        //            op       data   hold  r  icw1  vec    cas    icw4   mask   lvl arm smm ris pulses
        vt[0]  = '{OP_A0,   8'hFF, 1, e(0, 4'h0, 8'h00, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[1]  = '{OP_ICW1, 8'h13, 1, e(0, 4'h3, 8'h00, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[2]  = '{OP_A0,   8'h20, 1, e(0, 4'h3, 8'h20, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[3]  = '{OP_A0,   8'h03, 1, e(1, 4'h3, 8'h20, 8'h00, 5'h03, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[4]  = '{OP_ICW1, 8'h10, 1, e(0, 4'h0, 8'h20, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[5]  = '{OP_A0,   8'h08, 1, e(0, 4'h0, 8'h08, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[6]  = '{OP_A0,   8'h04, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[7]  = '{OP_A0,   8'hFB, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 0, 0, 0, 0, 6'b000000)};
        vt[8]  = '{OP_OCW2, 8'h20, 3, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 0, 0, 0, 0, 6'b100000)};
        vt[9]  = '{OP_OCW2, 8'h63, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 3, 0, 0, 0, 6'b010000)};
        vt[10] = '{OP_OCW2, 8'h80, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 0, 1, 0, 0, 6'b000000)};
        vt[11] = '{OP_OCW2, 8'hA5, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 5, 1, 0, 0, 6'b001000)};
        vt[12] = '{OP_OCW2, 8'hE2, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 2, 1, 0, 0, 6'b000100)};
        vt[13] = '{OP_OCW2, 8'hC7, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 7, 1, 0, 0, 6'b000010)};
        vt[14] = '{OP_OCW2, 8'h41, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 1, 1, 0, 0, 6'b000000)};
        vt[15] = '{OP_OCW3, 8'h0B, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 1, 1, 0, 1, 6'b000000)};
        vt[16] = '{OP_OCW3, 8'h68, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 1, 1, 1, 1, 6'b000000)};
        vt[17] = '{OP_OCW3, 8'h0C, 2, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 1, 1, 1, 1, 6'b000001)};
        vt[18] = '{OP_OCW2, 8'h00, 1, e(1, 4'h0, 8'h08, 8'h04, 5'h00, 8'hFB, 0, 0, 1, 1, 6'b000000)};
        vt[19] = '{OP_ICW1, 8'h17, 1, e(0, 4'h7, 8'h08, 8'h04, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[20] = '{OP_OCW2, 8'h20, 1, e(0, 4'h7, 8'h08, 8'h04, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[21] = '{OP_OCW3, 8'h0B, 1, e(0, 4'h7, 8'h08, 8'h04, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[22] = '{OP_A0,   8'h30, 1, e(0, 4'h7, 8'h30, 8'h04, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[23] = '{OP_A0,   8'h1F, 1, e(1, 4'h7, 8'h30, 8'h04, 5'h1F, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[24] = '{OP_OCW3, 8'h60, 1, e(1, 4'h7, 8'h30, 8'h04, 5'h1F, 8'h00, 0, 0, 1, 0, 6'b000000)};
        vt[25] = '{OP_OCW3, 8'h44, 1, e(1, 4'h7, 8'h30, 8'h04, 5'h1F, 8'h00, 0, 0, 0, 0, 6'b000001)};
        vt[26] = '{OP_A0,   8'h5A, 1, e(1, 4'h7, 8'h30, 8'h04, 5'h1F, 8'h5A, 0, 0, 0, 0, 6'b000000)};
        vt[27] = '{OP_BOTH, 8'h11, 1, e(0, 4'h1, 8'h30, 8'h04, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[28] = '{OP_A0,   8'h40, 1, e(0, 4'h1, 8'h40, 8'h04, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        // after the mid-sequence reset
        vt[29] = '{OP_A0,   8'hFF, 1, e(0, 4'h0, 8'h00, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[30] = '{OP_ICW1, 8'h12, 1, e(0, 4'h2, 8'h00, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[31] = '{OP_A0,   8'h99, 1, e(1, 4'h2, 8'h99, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b000000)};
        vt[32] = '{OP_OCW2, 8'h20, 2, e(1, 4'h2, 8'h99, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b100000)};

        // Reset is asserted from time zero; outputs must already be cleared.
        #3;
        check("reset_initial", e(0, 4'h0, 8'h00, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b0));
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < NPRE; i++) apply(i);

        // Asynchronous reset while waiting for ICW3, mid-cycle between edges.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_icw3", e(0, 4'h0, 8'h00, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b0));
        @(posedge clock);
        #1;
        check("reset_held", e(0, 4'h0, 8'h00, 8'h00, 5'h00, 8'h00, 0, 0, 0, 0, 6'b0));
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = NPRE; i < NVEC; i++) apply(i);

        repeat (2) @(posedge clock);
        #1;
        check("idle_tail", vt[NVEC-1].exp & ~obs_t'(6'b111111));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
